// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared FSM state encodings for the hazard/stall controller
package hazard_ctrl_pkg;
    typedef enum logic [1:0] {
        HC_IDLE    = 2'd0,
        HC_MD_BUSY = 2'd1,
        HC_MD_DONE = 2'd2
    } hc_state_e;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare between the EX load and the ID source registers
module hazard_detect (
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic       ID_use_rs1,
    input  logic       ID_use_rs2,
    input  logic [4:0] EX_rd,
    input  logic       EX_memread,
    output logic       load_use
);
    assign load_use = EX_memread && EX_rd != 5'd0 &&
                      ((ID_use_rs1 && EX_rd == ID_rs1) || (ID_use_rs2 && EX_rd == ID_rs2));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush, MUL/DIV freeze sequencing and stall-cycle counter
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_memread,
    input  logic             EX_muldiv,
    input  logic             EX_branch_taken,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_write,
    output logic             IDEX_bubble,
    output logic             EXMEM_bubble,
    output logic             md_start,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);
    hc_state_e  state;
    logic [3:0] md_cnt;
    logic       load_use, idle, branch, issue, lu_stall, freeze;

    hazard_detect u_detect (
        .ID_rs1     (ID_rs1),
        .ID_rs2     (ID_rs2),
        .ID_use_rs1 (ID_use_rs1),
        .ID_use_rs2 (ID_use_rs2),
        .EX_rd      (EX_rd),
        .EX_memread (EX_memread),
        .load_use   (load_use)
    );

    // Reset masks every request so the pipeline sees plain pass-through while rst_i is high.
    assign idle     = !rst_i && state == HC_IDLE;
    assign branch   = idle && EX_branch_taken;
    assign issue    = idle && !EX_branch_taken && EX_muldiv;
    assign lu_stall = idle && !EX_branch_taken && !EX_muldiv && load_use;
    assign freeze   = issue || (!rst_i && state == HC_MD_BUSY);

    assign PC_write     = !(freeze || lu_stall);
    assign IFID_write   = !(freeze || lu_stall);
    assign IFID_flush   = branch;
    assign IDEX_write   = !freeze;
    assign IDEX_bubble  = branch || lu_stall;
    assign EXMEM_bubble = freeze;
    assign md_start     = issue;
    assign md_done      = !rst_i && state == HC_MD_DONE;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= HC_IDLE;
            md_cnt    <= 4'd0;
            stall_cnt <= '0;
        end else begin
            stall_cnt <= (!PC_write && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
            case (state)
                HC_IDLE: begin
                    if (issue) begin
                        state  <= HC_MD_BUSY;
                        md_cnt <= 4'(MD_LAT - 3);
                    end
                end
                HC_MD_BUSY: begin
                    if (md_cnt == 4'd0) state <= HC_MD_DONE;
                    else md_cnt <= md_cnt - 4'd1;
                end
                default: state <= HC_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a cycle-count reference model
module tb_hazard_ctrl;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 16;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_i;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic ID_use_rs1, ID_use_rs2, EX_memread, EX_muldiv, EX_branch_taken;
    logic PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble, EXMEM_bubble, md_start, md_done;
    logic [CNT_W-1:0] stall_cnt;

    int tests = 0, fails = 0;
    int age = 0, cyc_n = 0, n_start = 0, n_done = 0, n_frz = 0, done_at = -1;
    int unsigned mcnt = 0;
    int start_at[$];
    logic m_pc, m_ifw, m_flush, m_idw, m_idb, m_exb, m_start, m_done;
    logic [CNT_W-1:0] s0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .EX_rd(EX_rd), .EX_memread(EX_memread), .EX_muldiv(EX_muldiv), .EX_branch_taken(EX_branch_taken),
        .PC_write(PC_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush), .IDEX_write(IDEX_write),
        .IDEX_bubble(IDEX_bubble), .EXMEM_bubble(EXMEM_bubble), .md_start(md_start), .md_done(md_done),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got=%h exp=%h", nm, cyc_n, got, exp);
        end
    endtask

    // age counts cycles since a MUL/DIV issued: 1..MD_LAT-2 frozen, MD_LAT-1 result cycle
    task automatic model_eval();
        logic lu;
        lu = EX_memread && EX_rd != 0 &&
             ((ID_use_rs1 && EX_rd == ID_rs1) || (ID_use_rs2 && EX_rd == ID_rs2));
        {m_pc, m_ifw, m_idw} = 3'b111;
        {m_flush, m_idb, m_exb, m_start, m_done} = 5'b0;
        if (!rst_i) begin
            if (age == 0) begin
                if (EX_branch_taken) {m_flush, m_idb} = 2'b11;
                else if (EX_muldiv) begin
                    {m_pc, m_ifw, m_idw} = 3'b000;
                    {m_exb, m_start} = 2'b11;
                end else if (lu) begin
                    {m_pc, m_ifw} = 2'b00;
                    m_idb = 1'b1;
                end
            end else if (age < MD_LAT - 1) begin
                {m_pc, m_ifw, m_idw} = 3'b000;
                m_exb = 1'b1;
            end else m_done = 1'b1;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_eval();
        chk("outputs", {24'd0, PC_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble, EXMEM_bubble, md_start, md_done},
            {24'd0, m_pc, m_ifw, m_flush, m_idw, m_idb, m_exb, m_start, m_done});
        chk("stall_cnt", 32'(stall_cnt), mcnt);
        if (md_start) start_at.push_back(cyc_n);
        if (md_done) begin n_done++; done_at = cyc_n; end
        n_start += int'(md_start);
        n_frz += int'(!PC_write);
        @(posedge clk);
        if (rst_i) begin
            age = 0;
            mcnt = 0;
        end else begin
            if (!m_pc && mcnt < CNT_MAX) mcnt++;
            age = (age == 0) ? (m_start ? 1 : 0) : (age == MD_LAT - 1 ? 0 : age + 1);
        end
        cyc_n++;
        #1;
    endtask

    task automatic clear();
        {ID_rs1, ID_rs2, EX_rd} = '0;
        {ID_use_rs1, ID_use_rs2, EX_memread, EX_muldiv, EX_branch_taken} = '0;
    endtask

    task automatic reset_stats();
        n_start = 0; n_done = 0; n_frz = 0; done_at = -1;
        start_at.delete();
    endtask

    initial begin
        clear();
        rst_i = 1'b1;
        EX_memread = 1; EX_rd = 5; ID_rs1 = 5; ID_use_rs1 = 1;
        #1 chk("reset_passthrough", {29'd0, PC_write, IFID_write, IDEX_write}, 32'd7);
        cyc(); cyc();
        rst_i = 1'b0;
        // 1: load-use single bubble
        #1 chk("t1_stall", {30'd0, PC_write, IDEX_bubble}, 32'b01);
        chk("t1_cnt0", 32'(stall_cnt), 0);
        cyc();
        chk("t1_cnt1", 32'(stall_cnt), 1);
        clear();
        #1 chk("t1_release", {29'd0, PC_write, IFID_write, IDEX_write}, 32'd7);
        cyc();
        // 2: no stall cases
        EX_memread = 1; EX_rd = 0; ID_rs1 = 0; ID_use_rs1 = 1;
        #1 chk("t2_rd0", 32'(PC_write), 1);
        cyc();
        clear();
        EX_memread = 1; EX_rd = 5; ID_rs2 = 5; ID_use_rs2 = 0;
        #1 chk("t2_nors2", 32'(PC_write), 1);
        cyc();
        // 3: branch overrides load-use
        EX_memread = 1; EX_rd = 7; ID_rs1 = 7; ID_use_rs1 = 1; EX_branch_taken = 1;
        s0 = stall_cnt;
        #1 chk("t3_branch", {29'd0, IFID_flush, IDEX_bubble, PC_write}, 32'b111);
        cyc();
        chk("t3_cnt", 32'(stall_cnt), 32'(s0));
        clear();
        // 4: single MUL/DIV with EX_muldiv held through the result cycle
        reset_stats();
        s0 = stall_cnt;
        EX_muldiv = 1;
        repeat (MD_LAT) cyc();
        EX_muldiv = 0;
        cyc();
        chk("t4_starts", n_start, 1);
        chk("t4_dones", n_done, 1);
        chk("t4_done_at", done_at - start_at[0], MD_LAT - 1);
        chk("t4_freeze", n_frz, MD_LAT - 1);
        chk("t4_cnt", 32'(stall_cnt - s0), MD_LAT - 1);
        // 5: back-to-back MUL/DIV
        reset_stats();
        EX_muldiv = 1;
        repeat (2 * MD_LAT) cyc();
        EX_muldiv = 0;
        cyc();
        chk("t5_starts", n_start, 2);
        if (start_at.size() == 2) chk("t5_gap", start_at[1] - start_at[0], MD_LAT);
        else chk("t5_gap_count", start_at.size(), 2);
        chk("t5_freeze", n_frz, 2 * (MD_LAT - 1));
        // 6: reset while busy aborts the operation
        EX_muldiv = 1;
        cyc(); cyc();
        EX_muldiv = 0;
        reset_stats();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        #1 chk("t6_enables", {29'd0, PC_write, IFID_write, IDEX_write}, 32'd7);
        chk("t6_cnt", 32'(stall_cnt), 0);
        repeat (MD_LAT + 2) cyc();
        chk("t6_no_done", n_done, 0);
        // random traffic
        repeat (3000) begin
            rst_i = ($urandom_range(0, 99) < 2);
            ID_rs1 = 5'($urandom_range(0, 3));
            ID_rs2 = 5'($urandom_range(0, 3));
            EX_rd = 5'($urandom_range(0, 3));
            ID_use_rs1 = 1'($urandom);
            ID_use_rs2 = 1'($urandom);
            EX_memread = ($urandom_range(0, 99) < 40);
            EX_muldiv = ($urandom_range(0, 99) < 15);
            EX_branch_taken = ($urandom_range(0, 99) < 10);
            cyc();
        end
        // saturation: continuous load-use stall
        clear();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        EX_memread = 1; EX_rd = 9; ID_rs2 = 9; ID_use_rs2 = 1;
        repeat (CNT_MAX + 4) cyc();
        chk("sat", 32'(stall_cnt), 32'h0000FFFF);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
